// File: rtl/fpu_pkg.sv
// Shared FPU definitions: binary32 field widths, special encodings, divider FSM states.
package fpu_pkg;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned BIAS  = 127;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

  // Special-case outcome decided when the operands are accepted
  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;

endpackage

// File: rtl/fdiv_round.sv
// Combinational normalize / RNE round / range check / pack for the sequential divider.
module fdiv_round
  import fpu_pkg::*;
(
  input  logic              sign,
  input  logic signed [9:0] e,
  input  logic [24:0]       q,
  input  logic              sticky,
  input  special_t          spec,
  output logic [31:0]       y,
  output logic              ovf,
  output logic              udf
);

  logic              inc;
  logic [24:0]       sig;
  logic              carry;
  logic signed [9:0] e_r;
  logic [MAN_W-1:0]  frac;

  // Round the 24-bit significand q[24:1] with guard q[0], then select the packed result
  always_comb begin
    inc   = q[0] & (sticky | q[1]);
    sig   = {1'b0, q[24:1]} + {24'd0, inc};
    carry = sig[24];
    e_r   = carry ? e + 10'sd1 : e;
    // on carry the significand is exactly 1.0, so the shifted fraction is all zero
    frac  = carry ? sig[23:1] : sig[22:0];
    y     = '0;
    ovf   = 1'b0;
    udf   = 1'b0;
    case (spec)
      SP_NAN:  y = QNAN;
      SP_INF:  y = {sign, POS_INF[30:0]};
      SP_ZERO: y = {sign, 31'd0};
      default: begin
        if (e_r >= 10'sd255) begin
          y   = {sign, POS_INF[30:0]};
          ovf = 1'b1;
        end else if (e_r <= 10'sd0) begin
          y   = {sign, 31'd0};
          udf = 1'b1;
        end else begin
          y = {sign, e_r[EXP_W-1:0], frac};
        end
      end
    endcase
  end

endmodule

// File: rtl/fdiv_seq.sv
// Sequential binary32 divider y = x1 / x2: 25-step restoring mantissa division,
// valid/ready on both sides, one operation in flight, uniform 26-cycle latency.
module fdiv_seq
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf,
  output logic        udf
);

  state_t            state;
  logic [4:0]        count;
  logic [25:0]       rem;
  logic [MAN_W:0]    divisor;
  logic [24:0]       quo;
  logic              sign;
  logic signed [9:0] exp_q;
  special_t          spec;

  logic [EXP_W-1:0]  e1, e2;
  logic [MAN_W-1:0]  m1, m2;
  logic              z1, z2, inf1, inf2, nan1, nan2, adj;
  logic [MAN_W:0]    ma, mb;
  logic [MAN_W+1:0]  ma_n;
  logic signed [9:0] e_n;
  special_t          spec_n;

  logic              ge;
  logic [25:0]       diff, pick, rem_n;

  logic [31:0]       r_y;
  logic              r_ovf, r_udf;

  assign in_ready = (state == IDLE);

  // Operand decode at accept: classification, mantissa pre-alignment, biased exponent
  always_comb begin
    e1     = x1[30:23];
    e2     = x2[30:23];
    m1     = x1[22:0];
    m2     = x2[22:0];
    z1     = (e1 == '0);
    z2     = (e2 == '0);
    inf1   = (e1 == '1) && (m1 == '0);
    inf2   = (e2 == '1) && (m2 == '0);
    nan1   = (e1 == '1) && (m1 != '0);
    nan2   = (e2 == '1) && (m2 != '0);
    ma     = {1'b1, m1};
    mb     = {1'b1, m2};
    adj    = (ma < mb);
    ma_n   = adj ? {ma, 1'b0} : {1'b0, ma};
    e_n    = 10'(e1) - 10'(e2) + 10'(BIAS) - 10'(adj);
    spec_n = SP_NONE;
    if (nan1 || nan2 || (z1 && z2) || (inf1 && inf2))
      spec_n = SP_NAN;
    else if (z2 || inf1)
      spec_n = SP_INF;
    else if (z1 || inf2)
      spec_n = SP_ZERO;
  end

  // One restoring-division step: subtract if possible, then shift the remainder
  always_comb begin
    ge    = (rem >= {2'b00, divisor});
    diff  = rem - {2'b00, divisor};
    pick  = ge ? diff : rem;
    rem_n = pick << 1;
  end

  fdiv_round u_round (
    .sign   (sign),
    .e      (exp_q),
    .q      (quo),
    .sticky (rem != '0),
    .spec   (spec),
    .y      (r_y),
    .ovf    (r_ovf),
    .udf    (r_udf)
  );

  // Control FSM with datapath registers and registered result outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      count     <= '0;
      rem       <= '0;
      divisor   <= '0;
      quo       <= '0;
      sign      <= 1'b0;
      exp_q     <= '0;
      spec      <= SP_NONE;
      out_valid <= 1'b0;
      y         <= '0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign    <= x1[31] ^ x2[31];
            exp_q   <= e_n;
            spec    <= spec_n;
            rem     <= {1'b0, ma_n};
            divisor <= mb;
            quo     <= '0;
            count   <= 5'd24;
            state   <= DIV;
          end
        end
        DIV: begin
          rem <= rem_n;
          quo <= {quo[23:0], ge};
          if (count == '0) state <= ROUND;
          else             count <= count - 5'd1;
        end
        ROUND: begin
          y         <= r_y;
          ovf       <= r_ovf;
          udf       <= r_udf;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
